// File: rtl/controller_l2_pkg.sv
// Shared types and constants for the layer-2 convolution sequencing controller.
package controller_l2_pkg;

  localparam int NUM_OUT_DEF      = 16;
  localparam int WIN_PER_FILL_DEF = 4;
  localparam int OCW_DEF          = 5;
  localparam int STATE_W          = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_CLR    = 4'd1,
    ST_LDFILT = 4'd2,
    ST_LDIMG  = 4'd3,
    ST_VIEW   = 4'd4,
    ST_MAC    = 4'd5,
    ST_STORE  = 4'd6,
    ST_NEXT   = 4'd7,
    ST_FIN    = 4'd8
  } stateT;

  // Counter width able to hold the values 0..n-1, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/controller_l2_if.sv
// Datapath-facing bundle of the layer-2 controller: kernel/image handshakes,
// datapath status inputs and the strobes the controller decodes from them.
interface controller_l2_if;

  logic kerValid, kerReady;
  logic imgValid, imgReady;
  logic fullFilter, fullTemp, emptyTemp, macDone, fullWR;
  logic rstFilter, rstTemp, rstCalc, rstWR;
  logic WEFilter, REFilter, WETemp, RETemp, WEview, REview, enCalc, ldWR, lastWR;

  modport master (
    input  kerValid, imgValid, fullFilter, fullTemp, emptyTemp, macDone, fullWR,
    output kerReady, imgReady, rstFilter, rstTemp, rstCalc, rstWR,
           WEFilter, REFilter, WETemp, RETemp, WEview, REview, enCalc, ldWR, lastWR
  );

  modport slave (
    output kerValid, imgValid, fullFilter, fullTemp, emptyTemp, macDone, fullWR,
    input  kerReady, imgReady, rstFilter, rstTemp, rstCalc, rstWR,
           WEFilter, REFilter, WETemp, RETemp, WEview, REview, enCalc, ldWR, lastWR
  );

endinterface

// File: rtl/ctrl_l2_counter.sv
// Clear/increment counter with a terminal-count flag; clear wins over increment.
module ctrl_l2_counter #(
  parameter int W    = 4,
  parameter int TERM = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         atTerm
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     count <= '0;
    else if (clr)  count <= '0;
    else if (inc)  count <= count + W'(1);
  end

  assign atTerm = (count == W'(TERM));

endmodule

// File: rtl/controller_l2.sv
// Layer-2 convolution sequencing controller: filter load, temp fills, per-window
// view/MAC/store. Optional CTRL_L2_PERF_EN adds busy-cycle and store-stall counters.
module controller_l2
  import controller_l2_pkg::*;
#(
  parameter int NUM_OUT      = NUM_OUT_DEF,
  parameter int WIN_PER_FILL = WIN_PER_FILL_DEF,
  parameter int OCW          = OCW_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  controller_l2_if.master       dp,
  output logic [OCW-1:0]        outIdx,
  output logic                  busy,
`ifdef CTRL_L2_PERF_EN
  output logic [31:0]           perfCycles,
  output logic [15:0]           perfStall,
`endif
  output logic                  done
);

  localparam int WCW = cntWidth(WIN_PER_FILL);

  stateT          state;
  logic           outTerm, winTerm;
  logic [WCW-1:0] winIdx;

  ctrl_l2_counter #(.W(OCW), .TERM(NUM_OUT - 1)) uOutCnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (state == ST_CLR),
    .inc    (state == ST_NEXT),
    .count  (outIdx),
    .atTerm (outTerm)
  );

  // Window counter wraps on every refill; a finishing job leaves it cleared too.
  ctrl_l2_counter #(.W(WCW), .TERM(WIN_PER_FILL - 1)) uWinCnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr    ((state == ST_CLR) || ((state == ST_NEXT) && winTerm)),
    .inc    (state == ST_NEXT),
    .count  (winIdx),
    .atTerm (winTerm)
  );

  winIdxInRange: assert property (@(posedge clk) disable iff (!rstn)
    winIdx <= WCW'(WIN_PER_FILL - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start)         state <= ST_CLR;
        ST_CLR:                       state <= ST_LDFILT;
        ST_LDFILT: if (dp.fullFilter) state <= ST_LDIMG;
        ST_LDIMG:  if (dp.fullTemp)   state <= ST_VIEW;
        // An empty temp buffer here means the fill was lost; go refill it.
        ST_VIEW:                      state <= dp.emptyTemp ? ST_LDIMG : ST_MAC;
        ST_MAC:    if (dp.macDone)    state <= ST_STORE;
        ST_STORE:  if (!dp.fullWR)    state <= ST_NEXT;
        ST_NEXT: begin
          if (outTerm)      state <= ST_FIN;
          else if (winTerm) state <= ST_LDIMG;
          else              state <= ST_VIEW;
        end
        ST_FIN:                       state <= ST_IDLE;
        default:                      state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    dp.kerReady  = 1'b0;
    dp.imgReady  = 1'b0;
    dp.rstFilter = 1'b0;
    dp.rstTemp   = 1'b0;
    dp.rstCalc   = 1'b0;
    dp.rstWR     = 1'b0;
    dp.WEFilter  = 1'b0;
    dp.REFilter  = 1'b0;
    dp.WETemp    = 1'b0;
    dp.RETemp    = 1'b0;
    dp.WEview    = 1'b0;
    dp.REview    = 1'b0;
    dp.enCalc    = 1'b0;
    dp.ldWR      = 1'b0;
    dp.lastWR    = 1'b0;
    done         = 1'b0;
    busy         = (state != ST_IDLE);
    case (state)
      ST_CLR: begin
        dp.rstFilter = 1'b1;
        dp.rstTemp   = 1'b1;
        dp.rstCalc   = 1'b1;
        dp.rstWR     = 1'b1;
      end
      ST_LDFILT: begin
        dp.kerReady = !dp.fullFilter;
        dp.WEFilter = dp.kerValid && !dp.fullFilter;
      end
      ST_LDIMG: begin
        dp.imgReady = !dp.fullTemp;
        dp.WETemp   = dp.imgValid && !dp.fullTemp;
      end
      ST_VIEW: begin
        dp.RETemp  = 1'b1;
        dp.WEview  = 1'b1;
        dp.rstCalc = 1'b1;
      end
      ST_MAC: begin
        dp.enCalc   = !dp.macDone;
        dp.REview   = !dp.macDone;
        dp.REFilter = !dp.macDone;
      end
      ST_STORE: begin
        dp.ldWR   = !dp.fullWR;
        dp.lastWR = !dp.fullWR && outTerm;
      end
      ST_NEXT:  dp.rstTemp = winTerm && !outTerm;
      ST_FIN:   done = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_L2_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perfCycles <= '0;
      perfStall  <= '0;
    end else if (state == ST_CLR) begin
      perfCycles <= '0;
      perfStall  <= '0;
    end else begin
      if (busy && (perfCycles != 32'hFFFF_FFFF)) perfCycles <= perfCycles + 32'd1;
      if ((state == ST_STORE) && dp.fullWR)      perfStall  <= perfStall + 16'd1;
    end
  end
`endif

endmodule
